// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: imem req/ack, the registered IF/ID output pair and the redirect/stall controls.
// FetchCount exists only when FETCH_FETCHCNT_EN is defined.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              ImemReq;
  logic [ADDR_W-1:0] ImemAddr;
  logic              ImemAck;
  logic [31:0]       ImemData;
  logic              Stall;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic [ADDR_W-1:0] AddOut;
  logic [31:0]       InstrOut;
  logic              InstrValid;
`ifdef FETCH_FETCHCNT_EN
  logic [31:0]       FetchCount;
`endif

  modport master (
    output ImemReq, ImemAddr, AddOut, InstrOut, InstrValid,
    input  ImemAck, ImemData, Stall, BranchTaken, BranchTarget
`ifdef FETCH_FETCHCNT_EN
    , output FetchCount
`endif
  );

  modport slave (
    input  ImemReq, ImemAddr, AddOut, InstrOut, InstrValid,
    output ImemAck, ImemData, Stall, BranchTaken, BranchTarget
`ifdef FETCH_FETCHCNT_EN
    , input FetchCount
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch (IF/ID writer): one outstanding imem req/ack, ack-to-output latency 1 cycle.
// Stall holds outputs (a word acked under stall is parked in HOLD); BranchTaken flushes; FETCH_FETCHCNT_EN adds FetchCount.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc, drop_addr, add_q, buf_add;
  logic [31:0]       instr_q, buf_instr;
  logic              vld_q, req_q;

  logic              ack;
  logic [ADDR_W-1:0] pc_inc, target;

  // Acks seen while no request is raised (including the first cycle out of reset) are ignored.
  assign ack    = bus.ImemAck & req_q;
  assign pc_inc = pc + ADDR_W'(PC_STEP);
  assign target = bus.BranchTarget & ~ADDR_W'(3);

  assign bus.ImemReq    = req_q;
  assign bus.ImemAddr   = (state == DROP) ? drop_addr : pc;
  assign bus.AddOut     = add_q;
  assign bus.InstrOut   = instr_q;
  assign bus.InstrValid = vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      drop_addr <= '0;
      add_q     <= '0;
      buf_add   <= '0;
      instr_q   <= '0;
      buf_instr <= '0;
      vld_q     <= 1'b0;
      req_q     <= 1'b0;
    end else if (bus.BranchTaken) begin
      vld_q <= 1'b0;
      pc    <= target;
      req_q <= 1'b1;
      case (state)
        // An un-acked request must still complete at its original address before refetching.
        FETCH:   if (req_q && !ack) begin
                   drop_addr <= pc;
                   state     <= DROP;
                 end
        HOLD:    state <= FETCH;
        default: state <= DROP;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (ack && bus.Stall) begin
            buf_instr <= bus.ImemData;
            buf_add   <= pc_inc;
            pc        <= pc_inc;
            req_q     <= 1'b0;
            state     <= HOLD;
          end else begin
            req_q <= 1'b1;
            if (ack) begin
              instr_q <= bus.ImemData;
              add_q   <= pc_inc;
              vld_q   <= 1'b1;
              pc      <= pc_inc;
            end else if (!bus.Stall) begin
              vld_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!bus.Stall) begin
            instr_q <= buf_instr;
            add_q   <= buf_add;
            vld_q   <= 1'b1;
            req_q   <= 1'b1;
            state   <= FETCH;
          end
        end
        default: begin
          vld_q <= 1'b0;
          if (ack) state <= FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_FETCHCNT_EN
  logic        deliver;
  logic [31:0] fetch_cnt;

  assign deliver = !bus.BranchTaken && !bus.Stall &&
                   (((state == FETCH) && ack) || (state == HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fetch_cnt <= '0;
    else if (deliver) fetch_cnt <= fetch_cnt + 32'd1;
  end

  assign bus.FetchCount = fetch_cnt;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run, checked by a queue-based scoreboard.
module tb_fetch_unit;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          deliveries = 0;
  int          lat_mode = 0;
  bit          noise = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] fc_model = '0;

  // Memory contents: unique word per aligned address; 0->0x11, 4->0x22, 8->0x33.
  function automatic logic [31:0] word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Instruction memory: latency per request is lat_mode wait cycles (random 0..3 when negative).
  int wait_cnt = 0;
  int cur_lat  = 0;
  initial begin
    bus.ImemAck  = 1'b0;
    bus.ImemData = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.ImemAck = 1'b0;
        wait_cnt    = 0;
      end else if (bus.ImemReq) begin
        if (wait_cnt == 0) cur_lat = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
        if (wait_cnt >= cur_lat) begin
          bus.ImemAck  = 1'b1;
          bus.ImemData = word(bus.ImemAddr);
          wait_cnt     = 0;
        end else begin
          bus.ImemAck  = 1'b0;
          bus.ImemData = $urandom;
          wait_cnt++;
        end
      end else begin
        wait_cnt     = 0;
        bus.ImemAck  = noise && ($urandom_range(1, 0) == 1);
        bus.ImemData = $urandom;
      end
    end
  end

  // Monitor: inputs sampled at the edge, outputs checked 1ns later.
  logic        m_st, m_br, m_rq, m_ak, m_pv;
  logic [31:0] m_ad, m_pi, m_pa, m_e;
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        m_st = bus.Stall;   m_br = bus.BranchTaken;
        m_rq = bus.ImemReq; m_ak = bus.ImemAck;  m_ad = bus.ImemAddr;
        m_pi = bus.InstrOut; m_pa = bus.AddOut;  m_pv = bus.InstrValid;
        #1;
        if (rst_n) begin
          if (m_br) begin
            chk("flush_invalid", 32'(bus.InstrValid), 32'd0);
          end else if (m_st) begin
            chk("stall_instr_hold", bus.InstrOut, m_pi);
            chk("stall_add_hold", bus.AddOut, m_pa);
            if (!m_pv) chk("stall_no_new_valid", 32'(bus.InstrValid), 32'd0);
          end else if (bus.InstrValid) begin
            chk("sb_has_expected", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0) begin
              m_e = exp_q.pop_front();
              chk("deliv_instr", bus.InstrOut, word(m_e));
              chk("deliv_add", bus.AddOut, m_e + 32'd4);
              exp_q.push_back(m_e + 32'd4);
              deliveries++;
              fc_model++;
            end
          end
          if (m_rq && !m_ak) begin
            chk("req_held", 32'(bus.ImemReq), 32'd1);
            chk("addr_stable", bus.ImemAddr, m_ad);
          end
`ifdef FETCH_FETCHCNT_EN
          chk("fetch_count", bus.FetchCount, fc_model);
`endif
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // A branch restarts the expected instruction stream at the aligned target.
  task automatic drive(input logic st, input logic br, input logic [31:0] tgt);
    bus.Stall        = st;
    bus.BranchTaken  = br;
    bus.BranchTarget = tgt;
    if (br) begin
      exp_q.delete();
      exp_q.push_back(tgt & ~32'd3);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    fc_model = '0;
    repeat (2) cyc();
    chk("rst_req", 32'(bus.ImemReq), 32'd0);
    chk("rst_vld", 32'(bus.InstrValid), 32'd0);
    chk("rst_instr", bus.InstrOut, 32'd0);
    chk("rst_add", bus.AddOut, 32'd0);
`ifdef FETCH_FETCHCNT_EN
    chk("rst_fetch_count", bus.FetchCount, 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  task automatic wait_addr(input string nm, input logic [31:0] a);
    int n = 0;
    while (!(bus.ImemReq && bus.ImemAddr == a) && n < 50) begin
      cyc();
      n++;
    end
    chk({nm, "_req"}, 32'(bus.ImemReq), 32'd1);
    chk(nm, bus.ImemAddr, a);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.InstrValid && n < 50) begin
      cyc();
      n++;
    end
    chk(nm, 32'(bus.InstrValid), 32'd1);
  endtask

  int          nv, n;
  logic        seen, st_r, br_r, prev_br;
  logic [31:0] tgt_r;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0);

    // Back-to-back acks from reset.
    lat_mode = 0;
    apply_reset();
    wait_addr("t1_addr0", 32'h0);
    cyc();
    chk("t1_vld_next", 32'(bus.InstrValid), 32'd1);
    chk("t1_instr0", bus.InstrOut, 32'h11);
    chk("t1_add0", bus.AddOut, 32'h4);
    chk("t1_addr4", bus.ImemAddr, 32'h4);
    cyc();
    chk("t1_instr1", bus.InstrOut, 32'h22);
    chk("t1_add1", bus.AddOut, 32'h8);
    chk("t1_addr8", bus.ImemAddr, 32'h8);
    cyc();
    chk("t1_instr2", bus.InstrOut, 32'h33);
    chk("t1_add2", bus.AddOut, 32'hC);

    // Two wait cycles per request: one valid cycle in every three.
    lat_mode = 2;
    repeat (6) cyc();
    nv = 0;
    repeat (12) begin
      cyc();
      if (bus.InstrValid) nv++;
    end
    chk("t2_valid_per_12", 32'(nv), 32'd4);

    // Stall on the ack of address 4, held 3 cycles.
    lat_mode = 0;
    apply_reset();
    wait_addr("t3_addr4", 32'h4);
    drive(1'b1, 1'b0, 32'd0);
    repeat (3) cyc();
    chk("t3_hold_req", 32'(bus.ImemReq), 32'd0);
    chk("t3_hold_instr", bus.InstrOut, 32'h11);
    chk("t3_hold_add", bus.AddOut, 32'h4);
    drive(1'b0, 1'b0, 32'd0);
    cyc();
    chk("t3_rel_vld", 32'(bus.InstrValid), 32'd1);
    chk("t3_rel_instr", bus.InstrOut, 32'h22);
    chk("t3_rel_add", bus.AddOut, 32'h8);
    chk("t3_next_req", 32'(bus.ImemReq), 32'd1);
    chk("t3_next_addr", bus.ImemAddr, 32'h8);

    // Branch while address 8 is outstanding.
    lat_mode = 2;
    apply_reset();
    wait_addr("t4_addr8", 32'h8);
    chk("t4_unacked", 32'(bus.ImemAck), 32'd0);
    drive(1'b0, 1'b1, 32'h100);
    cyc();
    drive(1'b0, 1'b0, 32'd0);
    seen = 1'b0;
    n = 0;
    while (!(bus.ImemReq && bus.ImemAddr != 32'h8) && n < 20) begin
      if (bus.InstrValid) seen = 1'b1;
      cyc();
      n++;
    end
    chk("t4_no_valid_in_drop", 32'(seen), 32'd0);
    chk("t4_next_addr", bus.ImemAddr, 32'h100);
    wait_valid("t4_vld");
    chk("t4_instr", bus.InstrOut, word(32'h100));
    chk("t4_add", bus.AddOut, 32'h104);

    // Branch overriding a stall, unaligned target.
    lat_mode = 0;
    drive(1'b1, 1'b1, 32'h103);
    cyc();
    chk("t5_flush", 32'(bus.InstrValid), 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    wait_valid("t5_vld");
    chk("t5_instr", bus.InstrOut, word(32'h100));
    chk("t5_add", bus.AddOut, 32'h104);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFF8);
    cyc();
    drive(1'b0, 1'b0, 32'd0);
    wait_valid("wrap_vld");
    chk("wrap_add0", bus.AddOut, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_instr1", bus.InstrOut, word(32'hFFFF_FFFC));
    chk("wrap_add1", bus.AddOut, 32'h0);
    chk("wrap_next_addr", bus.ImemAddr, 32'h0);

    // Asynchronous reset while parked in HOLD.
    repeat (3) cyc();
    drive(1'b1, 1'b0, 32'd0);
    repeat (2) cyc();
    chk("t6_hold_req", 32'(bus.ImemReq), 32'd0);
    chk("t6_hold_vld", 32'(bus.InstrValid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_req", 32'(bus.ImemReq), 32'd0);
    chk("t6_async_vld", 32'(bus.InstrValid), 32'd0);
    chk("t6_async_instr", bus.InstrOut, 32'd0);
    chk("t6_async_add", bus.AddOut, 32'd0);
`ifdef FETCH_FETCHCNT_EN
    chk("t6_async_fetch_count", bus.FetchCount, 32'd0);
`endif
    apply_reset();
    wait_addr("t6_restart_addr", RESET_PC);

    // Randomized stalls, branches, latencies and stray acks.
    apply_reset();
    lat_mode   = -1;
    noise      = 1'b1;
    deliveries = 0;
    prev_br    = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      st_r  = ($urandom_range(3, 0) == 0);
      br_r  = !prev_br && ($urandom_range(19, 0) == 0);
      tgt_r = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                          : {16'h0, 16'($urandom)};
      drive(st_r, br_r, tgt_r);
      prev_br = br_r;
      cyc();
    end
    drive(1'b0, 1'b0, 32'd0);
    noise = 1'b0;
    repeat (10) cyc();
    chk("rand_progress", 32'(deliveries > 500), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; the writer side of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a req/ack handshake, which allows multi-cycle latency.
- Presents the fetched instruction and its PC+4 as a registered, valid-qualified pair for the IF/ID register to sample.
- Honours a downstream stall and a branch redirect from the execute/hazard logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, PC increment per sequential fetch
ADDR_W, 32, address/PC width; instruction width fixed at 32

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ImemReq  output  1  fetch request to instruction memory
ImemAddr  output  ADDR_W  fetch address; stable while ImemReq=1 and ImemAck=0
ImemAck  input  1  memory returns ImemData this cycle; sampled only when ImemReq=1
ImemData  input  32  instruction word
Stall  input  1  downstream cannot accept; outputs must hold
BranchTaken  input  1  redirect and flush, single-cycle pulse
BranchTarget  input  ADDR_W  redirect address
AddOut  output  ADDR_W  PC+PC_STEP of delivered instruction (to IF/ID AddIn)
InstrOut  output  32  delivered instruction (to IF/ID ImemoryIn)
InstrValid  output  1  AddOut/InstrOut hold a real instruction; 0 = bubble

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - PC=RESET_PC, state=FETCH.
  - ImemReq=0, AddOut=0, InstrOut=0, InstrValid=0, buffer cleared.
  - The first request is issued in the first cycle after rst_n rises.
- PC arithmetic:
  - Modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
  - BranchTarget low 2 bits are forced to 0 on load.
- States: FETCH, HOLD, DROP. ImemAddr=PC in FETCH, DropAddr in DROP.
- FETCH (ImemReq=1):
  - ack & !Stall: InstrOut<=ImemData, AddOut<=PC+PC_STEP, InstrValid<=1, PC<=PC+PC_STEP. Latency = 1 cycle from ack to output.
  - ack & Stall: ImemData and PC+PC_STEP go into the hold buffer, PC advances, go HOLD. Outputs are unchanged.
  - !ack & !Stall: InstrValid<=0 (bubble). Request and address are held.
  - !ack & Stall: outputs are held and the request is held.
- HOLD (ImemReq=0):
  - Outputs are held while Stall=1.
  - When Stall=0, the buffer moves to the outputs with InstrValid<=1, and the state returns to FETCH.
- DROP (ImemReq=1, ImemAddr=DropAddr):
  - Waits for the ack of an abandoned request.
  - On ack: data is discarded, go FETCH with PC unchanged.
  - InstrValid<=0 in every DROP cycle.
- BranchTaken has the highest priority, in any state, and overrides Stall. On BranchTaken:
  - InstrValid<=0, buffer discarded, PC<=BranchTarget.
  - From FETCH with ack in the same cycle: data discarded, stay FETCH.
  - From FETCH without ack: DropAddr<=PC, go DROP.
  - From HOLD: go FETCH.
  - From DROP: PC is reloaded and the state stays DROP.
- Only one request is ever outstanding. The address never changes while a request is un-acked.

Optional Feature:
- Macro FETCH_FETCHCNT_EN.
- When defined:
  - Adds output FetchCount, 32 bits, reset to 0.
  - Increments by 1 each cycle an instruction is newly delivered, i.e. InstrValid transitions to or re-asserts with new data.
  - Wraps at 2^32.
  - Held during Stall; never counts dropped or flushed words.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
1. Reset release, ImemAck=1 every cycle, words 0x11,0x22,0x33 -> ImemAddr 0,4,8. Then InstrOut 0x11/AddOut 4, 0x22/8, 0x33/12, with InstrValid=1 from the cycle after the first ack.
2. Memory ack after 2 cycles per request -> ImemAddr stable during the wait, one InstrValid=0 bubble per extra wait cycle, sequential PCs.
3. Stall=1 on the ack cycle of addr 4 (word 0x22), held 3 cycles -> state HOLD, ImemReq=0, outputs hold previous 0x11/4. After release: 0x22/AddOut 8, then a request to 8.
4. BranchTaken to 0x100 while addr 8 is un-acked -> ImemAddr stays 8 until ack, data discarded, next ImemAddr 0x100, InstrValid=0 throughout, then 0x100's word with AddOut 0x104.
5. BranchTaken with Stall=1, target 0x103 -> InstrValid=0 next cycle, fetch from 0x100.
6. rst_n low mid-HOLD -> outputs and ImemReq go 0 immediately without a clock edge. After release, fetch restarts at RESET_PC (FetchCount=0 when the macro is defined).
